// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the control unit and the
// sequential multiply/divide unit.
//   start_mult, start_div : operation requests (level, sampled while idle)
//   a, b                  : operands (rs, rt)
//   busy, done, div_zero  : status back to the control unit
//   hi, lo                : result pair for the HI/LO register mux
interface mult_div_unit_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_mult, start_div, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed 32x32 multiply / 32/32 divide.
// Works on operand magnitudes for 32 iterations (shift-add multiply or
// restoring divide), fixes up signs in one extra cycle, then pulses done.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mult_div_unit_if.slave (start_mult/start_div/a/b in,
//            busy/done/div_zero/hi/lo out)
// Build option:
//   MULTDIV_DIVZERO_EXC_EN : when defined, a divide with b==0 skips the
//   iteration, goes straight to DONE with div_zero set and leaves hi/lo
//   untouched. When undefined, div_zero is tied to 0 and a zero divisor runs
//   the normal divide.
module mult_div_unit (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] abs_a_q, abs_b_q;
  logic        sa_q, sb_q, is_div_q;
  logic [31:0] acc_hi_q;   // multiply: upper product / divide: remainder
  logic [31:0] acc_lo_q;   // multiply: multiplier    / divide: quotient
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        div_trap;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] prod, prod_neg;

  assign accept = (state_q == S_IDLE) && (bus.start_mult || bus.start_div);

`ifdef MULTDIV_DIVZERO_EXC_EN
  logic dz_q;
  assign div_trap = bus.start_div && !bus.start_mult && (bus.b == 32'd0);
`else
  assign div_trap = 1'b0;
`endif

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude
  assign a_abs = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_abs = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

  // 33-bit sum keeps the carry that becomes acc_hi[31] after the shift
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, abs_a_q} : 33'd0);

  // Shifted partial remainder needs 33 bits for the compare; the remainder
  // after a restoring step is always < |b|, so 32 bits suffice to store it.
  assign div_sh  = {acc_hi_q, acc_lo_q[31]};
  assign div_ge  = div_sh >= {1'b0, abs_b_q};
  assign div_rem = div_ge ? (div_sh[31:0] - abs_b_q) : div_sh[31:0];

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod + 64'd1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_mult)     state_d = S_MULT;
        else if (bus.start_div) state_d = div_trap ? S_DONE : S_DIV;
      end
      S_MULT:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_DIV:   if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    bus.done     = (state_q == S_DONE);
`ifdef MULTDIV_DIVZERO_EXC_EN
    bus.div_zero = (state_q == S_DONE) && dz_q;
`else
    bus.div_zero = 1'b0;
`endif
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          abs_a_q  <= a_abs;
          abs_b_q  <= b_abs;
          sa_q     <= bus.a[31];
          sb_q     <= bus.b[31];
          is_div_q <= !bus.start_mult;
          cnt_q    <= '0;
          acc_hi_q <= '0;
          acc_lo_q <= bus.start_mult ? b_abs : a_abs;
        end
        S_MULT: begin
          acc_hi_q <= mul_sum[32:1];
          acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
          cnt_q    <= cnt_q + 6'd1;
        end
        S_DIV: begin
          acc_hi_q <= div_rem;
          acc_lo_q <= {acc_lo_q[30:0], div_ge};
          cnt_q    <= cnt_q + 6'd1;
        end
        S_FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= (sa_q ^ sb_q) ? prod_neg : prod;
          end else begin
            lo_q <= (sa_q ^ sb_q) ? (~acc_lo_q + 32'd1) : acc_lo_q;
            hi_q <= sa_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTDIV_DIVZERO_EXC_EN
  // Trap flag is captured on every acceptance so a stale flag never leaks
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dz_q <= 1'b0;
    else if (accept) dz_q <= div_trap;
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   pushes   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual hi=%h lo=%h required no pulse", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", bus.hi, e.hi);
        check("result_lo", bus.lo, e.lo);
        check("result_dz", {31'd0, bus.div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    pushes++;
  endtask

  // One operation: issue, drop start after acceptance, scramble operands,
  // measure latency and busy cycles, confirm done lasts one cycle.
  task automatic run_op(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input int lat, input bit disturb);
    int n, busy_n;
    bit seen;
    @(negedge clk);
    bus.start_mult = !is_div;
    bus.start_div  = is_div;
    bus.a = av;
    bus.b = bv;
    push_exp(eh, el, edz);
    @(posedge clk);
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    n = 1; busy_n = 0; seen = 1'b0;
    while (n <= 60) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin seen = 1'b1; break; end
      if (disturb && n == 5) bus.start_div = 1'b1;
      if (disturb && n == 6) bus.start_div = 1'b0;
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("busy_cycles", busy_n, lat - 1);
    if (seen) begin
      @(negedge clk);
      check("done_pulse_width", {31'd0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    int n;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_dz",   {31'd0, bus.div_zero}, 32'd0);
    check("reset_hi",   bus.hi, 32'd0);
    check("reset_lo",   bus.lo, 32'd0);
    reset = 1'b0;

    run_op(0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34, 0);
    run_op(0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 34, 0);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 34, 0);
    run_op(0, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 0, 34, 0);
    run_op(0, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001, 0, 34, 0);
    run_op(0, 32'd123456,   32'd654321,   32'h00000012, 32'hCEDABE40, 0, 34, 1);
    run_op(1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0);
    run_op(1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 0, 34, 0);
    run_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 0, 34, 0);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 34, 0);
`ifdef MULTDIV_DIVZERO_EXC_EN
    run_op(1, 32'd5,        32'd0,        32'h00000000, 32'h80000000, 1, 1, 0);
`else
    run_op(1, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 0, 34, 0);
`endif

    // Reset mid-multiply with both starts held
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.start_div  = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd4;
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_dz",   {31'd0, bus.div_zero}, 32'd0);
    check("abort_hi",   bus.hi, 32'd0);
    check("abort_lo",   bus.lo, 32'd0);
    @(negedge clk);
    push_exp(32'd0, 32'd12, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("accept_after_reset", {31'd0, bus.busy}, 32'd1);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    n = 1;
    while (n <= 60 && !bus.done) begin
      @(negedge clk);
      n++;
    end
    check("post_reset_latency", n, 34);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
